// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and pin vector type for the PWM peripheral
package pwm_pkg;

  localparam int         PWM_CNT_W        = 8;
  localparam logic [7:0] DUTY_FULL        = 8'hFF;
  localparam int         PRESCALE_DEFAULT = 13;
  localparam int         PIN_COUNT        = 16;

  typedef logic [PIN_COUNT-1:0] pin_vec_t;

endpackage

// File: rtl/pwm_peripheral_if.sv
// rtl/pwm_peripheral_if.sv - configuration-in / pin-drive-out bundle between register block and PWM
interface pwm_peripheral_if;
  import pwm_pkg::*;

  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  pin_vec_t   out;
  logic       period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output out, period_start
  );

endinterface

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - prescaler plus free-running wrap-around counter; tick/wrap are pre-update strobes
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT,
  parameter int CNT_W    = PWM_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] pwm_cnt,
  output logic             tick,
  output logic             wrap
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] prescaler;

  // With PRESCALE=1 the prescaler is pinned at 0, so tick is asserted every clk.
  assign tick = (prescaler == PS_LAST);
  assign wrap = tick && (pwm_cnt == '1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - 16-pin low/high/PWM output mux; PWM_SYNC_UPDATE_EN defers duty changes to period wrap
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT,
  parameter int CNT_W    = PWM_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  pwm_peripheral_if.slave  bus
);

  logic [CNT_W-1:0] pwm_cnt;
  logic             tick_unused;
  logic             wrap;
  logic [7:0]       duty_eff;
  logic             pwm_level;
  pin_vec_t         en_out;
  pin_vec_t         en_pwm;
  pin_vec_t         out_q;
  logic             period_start_q;

  pwm_timebase #(
    .PRESCALE (PRESCALE),
    .CNT_W    (CNT_W)
  ) u_timebase (
    .clk     (clk),
    .rst_n   (rst_n),
    .pwm_cnt (pwm_cnt),
    .tick    (tick_unused),
    .wrap    (wrap)
  );

`ifdef PWM_SYNC_UPDATE_EN
  logic [7:0] duty_shadow;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_shadow <= '0;
    end else if (wrap) begin
      duty_shadow <= bus.pwm_duty_cycle;
    end
  end

  assign duty_eff = duty_shadow;
`else
  assign duty_eff = bus.pwm_duty_cycle;
`endif

  // Full-scale duty is special-cased so 0xFF gives no one-step dip at count 255.
  assign pwm_level = (duty_eff == DUTY_FULL) || (pwm_cnt < duty_eff);

  assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      out_q          <= en_out & (~en_pwm | {PIN_COUNT{pwm_level}});
      period_start_q <= wrap;
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb/tb_pwm_peripheral.sv - directed scoreboard bench for pwm_peripheral at PRESCALE 13 and 1
module tb_pwm_peripheral;
  import pwm_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pwm_peripheral_if bus13 ();
  pwm_peripheral_if bus1 ();

  pwm_peripheral #(.PRESCALE(13)) dut13 (.clk(clk), .rst_n(rst_n), .bus(bus13));
  pwm_peripheral #(.PRESCALE(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   n;

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty observed='h%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) passed++;
      else $error("FAIL %s observed='h%0h expected='h%0h", e.tag, obs, e.val);
    end
  endtask

  function automatic pin_vec_t dout(input int s);
    return (s != 0) ? bus1.out : bus13.out;
  endfunction

  function automatic logic dps(input int s);
    return (s != 0) ? bus1.period_start : bus13.period_start;
  endfunction

  task automatic wait_ps(input int s, input int max, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (dps(s) !== 1'b1 && cnt < max);
  endtask

  task automatic run_len(input int s, input int b, input int max, output int cnt);
    pin_vec_t o;
    logic     v;
    o   = dout(s);
    v   = o[b];
    cnt = 0;
    while (cnt < max) begin
      o = dout(s);
      if (o[b] !== v) break;
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus13.en_reg_out_7_0  = 8'h00; bus13.en_reg_out_15_8 = 8'h00;
    bus13.en_reg_pwm_7_0  = 8'h00; bus13.en_reg_pwm_15_8 = 8'h00;
    bus13.pwm_duty_cycle  = 8'h00;
    bus1.en_reg_out_7_0   = 8'h00; bus1.en_reg_out_15_8  = 8'h00;
    bus1.en_reg_pwm_7_0   = 8'h00; bus1.en_reg_pwm_15_8  = 8'h00;
    bus1.pwm_duty_cycle   = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    push_exp("reset_out13", 32'h0);  check(32'(dout(0)));
    push_exp("reset_out1", 32'h0);   check(32'(dout(1)));
    push_exp("reset_ps13", 32'h0);   check(32'(dps(0)));

    // Static-high enables appear exactly one clk later
    rst_n = 1'b1;
    bus13.en_reg_out_7_0 = 8'hFF; bus13.en_reg_out_15_8 = 8'hFF;
    push_exp("static_before_edge", 32'h0);
    #1 check(32'(dout(0)));
    @(negedge clk);
    push_exp("static_high", 32'hFFFF); check(32'(dout(0)));
    repeat (5) @(negedge clk);

    // Mid-run reset clears outputs on the next posedge
    rst_n = 1'b0;
    @(negedge clk);
    push_exp("midrun_reset_out", 32'h0); check(32'(dout(0)));

    // Duty 0x80 on pin 0; PRESCALE=1 instance gets duty 0x01
    bus13.en_reg_out_7_0 = 8'h01; bus13.en_reg_out_15_8 = 8'h00;
    bus13.en_reg_pwm_7_0 = 8'h01; bus13.en_reg_pwm_15_8 = 8'h00;
    bus13.pwm_duty_cycle = 8'h80;
    bus1.en_reg_out_7_0  = 8'h01; bus1.en_reg_pwm_7_0 = 8'h01;
    bus1.pwm_duty_cycle  = 8'h01;
    @(negedge clk);
    rst_n = 1'b1;
    push_exp("first_ps_latency", 32'd3328);  wait_ps(0, 4000, n); check(32'(n));
    push_exp("ps_spacing", 32'd3328);        wait_ps(0, 4000, n); check(32'(n));
    @(negedge clk);
    push_exp("ps_one_clk", 32'h0);           check(32'(dps(0)));
    push_exp("d80_pins", 32'h0001);          check(32'(dout(0)));
    push_exp("d80_high", 32'd1664);          run_len(0, 0, 4000, n); check(32'(n));
    push_exp("d80_low_pins", 32'h0000);      check(32'(dout(0)));
    push_exp("d80_low", 32'd1664);           run_len(0, 0, 4000, n); check(32'(n));

    // Duty 0x00: constant low for two periods
    bus13.pwm_duty_cycle = 8'h00;
    wait_ps(0, 4000, n);
    @(negedge clk);
    push_exp("d00_level", 32'h0000);         check(32'(dout(0)));
    push_exp("d00_hold", 32'd6656);          run_len(0, 0, 6656, n); check(32'(n));

    // Duty 0xFF: constant high for two periods, no dip at count 255
    bus13.pwm_duty_cycle = 8'hFF;
    wait_ps(0, 4000, n);
    @(negedge clk);
    push_exp("dff_level", 32'h0001);         check(32'(dout(0)));
    push_exp("dff_hold", 32'd6656);          run_len(0, 0, 6656, n); check(32'(n));

    // Output enable dominates PWM enable; only pins 7..4 toggle
    bus13.en_reg_out_7_0 = 8'hF0; bus13.en_reg_out_15_8 = 8'h00;
    bus13.en_reg_pwm_7_0 = 8'hFF; bus13.en_reg_pwm_15_8 = 8'hFF;
    bus13.pwm_duty_cycle = 8'h40;
    push_exp("mask_sync", 32'h1);            wait_ps(0, 4000, n); check(32'(n < 4000));
    @(negedge clk);
    push_exp("mask_high_pins", 32'h00F0);    check(32'(dout(0)));
    push_exp("d40_high", 32'd832);           run_len(0, 4, 4000, n); check(32'(n));
    push_exp("mask_low_pins", 32'h0000);     check(32'(dout(0)));
    push_exp("d40_low", 32'd2496);           run_len(0, 4, 4000, n); check(32'(n));

    // Duty write 0x40 -> 0xC0 while pwm_cnt is 0x20
    wait_ps(0, 4000, n);
    repeat (416) @(negedge clk);
    bus13.pwm_duty_cycle = 8'hC0;
`ifdef PWM_SYNC_UPDATE_EN
    push_exp("upd_cur_high", 32'd417);
    push_exp("upd_cur_low", 32'd2496);
`else
    push_exp("upd_cur_high", 32'd2081);
    push_exp("upd_cur_low", 32'd832);
`endif
    run_len(0, 4, 4000, n); check(32'(n));
    run_len(0, 4, 4000, n); check(32'(n));
    push_exp("upd_next_high", 32'd2496);     run_len(0, 4, 4000, n); check(32'(n));
    push_exp("upd_next_low", 32'd832);       run_len(0, 4, 4000, n); check(32'(n));

    // PRESCALE=1, duty 0x01: one-clk pulse per 256-clk period
    wait_ps(1, 600, n);
    push_exp("p1_ps_spacing", 32'd256);      wait_ps(1, 600, n); check(32'(n));
    @(negedge clk);
    push_exp("p1_pins", 32'h0001);           check(32'(dout(1)));
    push_exp("p1_high", 32'd1);              run_len(1, 0, 600, n); check(32'(n));
    push_exp("p1_low", 32'd255);             run_len(1, 0, 600, n); check(32'(n));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
